// File: rtl/gerador_comandos_teclado.sv
// gerador_comandos_teclado: debounces the two KEY buttons and turns each press
// into one push/execute command, with the switch operand, on a valid/ready handshake.
module gerador_comandos_teclado #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] key_n,
    input  logic [7:0] sw_numero,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic       cmd_push,
    output logic       cmd_exec,
    output logic [7:0] cmd_dado,
    output logic [1:0] teclas_estaveis,
    output logic       descartado
);
    typedef enum logic {OCIOSO, PENDENTE} estado_t;

    localparam logic [CNT_W-1:0] LIMITE = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       r_sync1, r_sync2, r_est, r_est_d;
    logic [CNT_W-1:0] r_cnt [2];
    logic [1:0]       w_ev;
    logic             w_livre;
    estado_t          r_estado, w_estado;
    logic             r_push, w_push, r_exec, w_exec, r_desc, w_desc;
    logic [7:0]       r_dado, w_dado;

    // Stable level is kept as 1 = pressed; synchronised key_n is active-low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 2'b11;
            r_sync2 <= 2'b11;
            r_est   <= 2'b00;
            r_est_d <= 2'b00;
            r_cnt   <= '{default: '0};
        end else begin
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
            r_est_d <= r_est;
            for (int i = 0; i < 2; i++) begin
                if (~r_sync2[i] == r_est[i])
                    r_cnt[i] <= '0;
                else if (r_cnt[i] == LIMITE) begin
                    r_cnt[i] <= '0;
                    r_est[i] <= ~r_est[i];
                end else
                    r_cnt[i] <= r_cnt[i] + 1'b1;
            end
        end
    end

    assign w_ev    = r_est & ~r_est_d;
    assign w_livre = (r_estado == OCIOSO) || cmd_ready;

    // The command slot is free when idle or when the pending command transfers now.
    always_comb begin
        w_estado = r_estado;
        w_push   = r_push;
        w_exec   = r_exec;
        w_dado   = r_dado;
        w_desc   = 1'b0;
        if (w_livre) begin
            if (|w_ev) begin
                w_estado = PENDENTE;
                w_push   = w_ev[0];
                w_exec   = w_ev[1] & ~w_ev[0];
                w_dado   = sw_numero;
                w_desc   = &w_ev;
            end else begin
                w_estado = OCIOSO;
                w_push   = 1'b0;
                w_exec   = 1'b0;
            end
        end else
            w_desc = |w_ev;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_estado <= OCIOSO;
            r_push   <= 1'b0;
            r_exec   <= 1'b0;
            r_dado   <= 8'h00;
            r_desc   <= 1'b0;
        end else begin
            r_estado <= w_estado;
            r_push   <= w_push;
            r_exec   <= w_exec;
            r_dado   <= w_dado;
            r_desc   <= w_desc;
        end
    end

    assign cmd_valid       = (r_estado == PENDENTE);
    assign cmd_push        = r_push;
    assign cmd_exec        = r_exec;
    assign cmd_dado        = r_dado;
    assign teclas_estaveis = r_est;
    assign descartado      = r_desc;
endmodule

// File: tb/tb_gerador_comandos_teclado.sv
// tb_gerador_comandos_teclado: cycle-table and directed sequences for the
// keyboard command generator with DEBOUNCE_CYCLES=4.
module tb_gerador_comandos_teclado;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] key_n;
    logic [7:0] sw_numero;
    logic       cmd_ready;
    logic       cmd_valid, cmd_push, cmd_exec, descartado;
    logic [7:0] cmd_dado;
    logic [1:0] teclas_estaveis;

    int n_chk = 0;
    int n_err = 0;

    gerador_comandos_teclado #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .key_n(key_n), .sw_numero(sw_numero),
        .cmd_ready(cmd_ready), .cmd_valid(cmd_valid), .cmd_push(cmd_push),
        .cmd_exec(cmd_exec), .cmd_dado(cmd_dado),
        .teclas_estaveis(teclas_estaveis), .descartado(descartado)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] key;
        logic [7:0] sw;
        logic       rdy;
        logic       v;
        logic       p;
        logic       e;
        logic [7:0] d;
        logic [1:0] t;
        logic       x;
    } vec_t;

    vec_t tab[$];

    function automatic vec_t mk(logic [1:0] k, logic [7:0] s, logic r, logic v,
                                logic p, logic e, logic [7:0] d, logic [1:0] t, logic x);
        vec_t w;
        w.key = k; w.sw = s; w.rdy = r; w.v = v; w.p = p;
        w.e = e; w.d = d; w.t = t; w.x = x;
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, int got, int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Operand is only meaningful while a command is pending.
    task automatic chk_all(string tag, logic v, logic p, logic e, logic [7:0] d,
                           logic [1:0] t, logic x);
        chk({tag, ".valid"}, cmd_valid, v);
        chk({tag, ".push"}, cmd_push, p);
        chk({tag, ".exec"}, cmd_exec, e);
        chk({tag, ".teclas"}, teclas_estaveis, t);
        chk({tag, ".desc"}, descartado, x);
        if (v) chk({tag, ".dado"}, cmd_dado, d);
    endtask

    initial begin
        rst = 1'b0; key_n = 2'b11; sw_numero = 8'h00; cmd_ready = 1'b0;
        for (int i = 0; i < 5; i++) tab.push_back(mk(2'b10, 8'h2A, 0, 0, 0, 0, 8'h00, 2'b00, 0));
        tab.push_back(mk(2'b10, 8'h2A, 0, 0, 0, 0, 8'h00, 2'b01, 0));
        tab.push_back(mk(2'b10, 8'h2A, 0, 1, 1, 0, 8'h2A, 2'b01, 0));
        tab.push_back(mk(2'b10, 8'hFF, 0, 1, 1, 0, 8'h2A, 2'b01, 0));
        tab.push_back(mk(2'b10, 8'hFF, 1, 0, 0, 0, 8'h00, 2'b01, 0));
        tab.push_back(mk(2'b10, 8'hFF, 1, 0, 0, 0, 8'h00, 2'b01, 0));
        for (int i = 0; i < 4; i++) tab.push_back(mk(2'b10, 8'hFF, 0, 0, 0, 0, 8'h00, 2'b01, 0));

        #1;
        chk_all("reset", 0, 0, 0, 8'h00, 2'b00, 0);
        chk("reset.dado", cmd_dado, 8'h00);
        repeat (3) step();
        rst = 1'b1;
        repeat (3) step();
        chk_all("idle", 0, 0, 0, 8'h00, 2'b00, 0);

        for (int i = 0; i < tab.size(); i++) begin
            key_n = tab[i].key; sw_numero = tab[i].sw; cmd_ready = tab[i].rdy;
            step();
            chk_all($sformatf("vec%0d", i), tab[i].v, tab[i].p, tab[i].e, tab[i].d, tab[i].t, tab[i].x);
        end
        key_n = 2'b11; cmd_ready = 1'b0;
        repeat (8) step();
        chk("release.teclas", teclas_estaveis, 2'b00);

        for (int c = 0; c < 20; c++) begin
            key_n = ((c / 2) % 2 == 0) ? 2'b01 : 2'b11;
            step();
            chk($sformatf("bounce%0d.teclas", c), teclas_estaveis, 2'b00);
            chk($sformatf("bounce%0d.valid", c), cmd_valid, 0);
        end
        key_n = 2'b11;
        repeat (10) step();
        chk_all("bounce_end", 0, 0, 0, 8'h00, 2'b00, 0);

        key_n = 2'b00; sw_numero = 8'h05;
        repeat (6) step();
        chk_all("sim_pre", 0, 0, 0, 8'h00, 2'b11, 0);
        step();
        chk_all("sim", 1, 1, 0, 8'h05, 2'b11, 1);
        step();
        chk_all("sim_after", 1, 1, 0, 8'h05, 2'b11, 0);
        cmd_ready = 1'b1; step(); cmd_ready = 1'b0;
        chk_all("sim_done", 0, 0, 0, 8'h00, 2'b11, 0);
        key_n = 2'b11; repeat (8) step();

        key_n = 2'b10; sw_numero = 8'h11;
        repeat (7) step();
        chk_all("drop_cmd", 1, 1, 0, 8'h11, 2'b01, 0);
        key_n = 2'b00; sw_numero = 8'h22;
        repeat (6) step();
        chk_all("drop_pre", 1, 1, 0, 8'h11, 2'b11, 0);
        step();
        chk_all("drop_pulse", 1, 1, 0, 8'h11, 2'b11, 1);
        step();
        chk_all("drop_after", 1, 1, 0, 8'h11, 2'b11, 0);
        cmd_ready = 1'b1; step(); cmd_ready = 1'b0;
        chk_all("drop_done", 0, 0, 0, 8'h00, 2'b11, 0);
        key_n = 2'b11; repeat (8) step();

        key_n = 2'b10; sw_numero = 8'h33;
        repeat (7) step();
        chk_all("b2b_cmd", 1, 1, 0, 8'h33, 2'b01, 0);
        key_n = 2'b00; sw_numero = 8'h44;
        repeat (6) step();
        cmd_ready = 1'b1; step(); cmd_ready = 1'b0;
        chk_all("b2b_new", 1, 0, 1, 8'h44, 2'b11, 0);
        step();
        chk_all("b2b_hold", 1, 0, 1, 8'h44, 2'b11, 0);
        cmd_ready = 1'b1; step(); cmd_ready = 1'b0;
        chk_all("b2b_done", 0, 0, 0, 8'h00, 2'b11, 0);
        key_n = 2'b11; repeat (8) step();

        key_n = 2'b10; sw_numero = 8'h55;
        repeat (7) step();
        chk_all("rst_pend", 1, 1, 0, 8'h55, 2'b01, 0);
        #2 rst = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 0, 8'h00, 2'b00, 0);
        chk("async_rst.dado", cmd_dado, 8'h00);
        repeat (2) step();
        rst = 1'b1;
        repeat (6) step();
        chk_all("rst_pre", 0, 0, 0, 8'h00, 2'b01, 0);
        step();
        chk_all("rst_cmd", 1, 1, 0, 8'h55, 2'b01, 0);
        cmd_ready = 1'b1; step(); cmd_ready = 1'b0;
        chk_all("rst_done", 0, 0, 0, 8'h00, 2'b01, 0);
        for (int c = 0; c < 10; c++) begin
            step();
            chk($sformatf("held%0d.valid", c), cmd_valid, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
